hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller. It generates the control inputs that the ID/EXE pipeline register consumes: Control_flush, CSR_stall and CSR_reset.
- It also generates the IF-stage and IF/ID-stage enables and flushes.
- It detects load-use hazards and branch redirects, sequences multi-cycle CSR operations with a small FSM, and handles CSR trap flushes.
- It keeps stall and flush performance counters.

Parameters:
- CSR_LAT, 3, number of cycles CSR_stall is held per CSR instruction in EXE (legal range 1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- ID_rs1_addr  in  5  source register 1 of the instruction in ID
- ID_rs2_addr  in  5  source register 2 of the instruction in ID
- ID_use_rs1  in  1  instruction in ID reads rs1
- ID_use_rs2  in  1  instruction in ID reads rs2
- ID_rs1_f  in  1  rs1 is an FP register
- ID_rs2_f  in  1  rs2 is an FP register
- EXE_MemRead  in  1  load instruction in EXE
- EXE_write_addr  in  5  destination register of the instruction in EXE
- EXE_dest_f  in  1  EXE destination is in the FP register file
- EXE_CSRSel  in  1  CSR instruction in EXE
- branch_taken  in  1  EXE resolved a taken branch or jump
- csr_trap  in  1  CSR unit requests trap/return redirect (1-cycle pulse)
- im_stall  in  1  instruction memory busy
- dm_stall  in  1  data memory busy
- pc_write  out  1  PC register update enable
- IFID_write  out  1  IF/ID register load enable
- IFID_flush  out  1  IF/ID register clear
- Control_flush  out  1  bubble the control fields into ID/EXE
- CSR_stall  out  1  hold the whole pipeline during a CSR operation
- CSR_reset  out  1  clear ID/EXE and the downstream pipeline registers
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_count  out  CNT_W  count of branch flushes

Behaviour:
- FSM states:
  - IDLE
  - CSR_BUSY (4-bit down-counter cnt)
  - CSR_DONE
  - TRAP
- Outputs are combinational from state and inputs.
- While reset=1:
  - All six control outputs are 0.
  - Next state is IDLE, cnt=0, both counters are 0.
- After reset is released (IDLE, no events): pc_write=1, IFID_write=1, all other control outputs are 0.
- Load-use hazard, lu, is 1 when all of the following hold:
  - EXE_MemRead=1;
  - for rs1 or rs2: use_rsN=1, rsN_addr==EXE_write_addr and rsN_f==EXE_dest_f;
  - an integer destination x0 never hazards; FP f0 does.
- mem = im_stall | dm_stall.
- Priority per cycle (highest first):
  1. TRAP state: CSR_reset=1, IFID_flush=1, pc_write=1, IFID_write=0. Next state is IDLE unconditionally.
  2. csr_trap=1 in any state: the combinational outputs of the current state are suppressed to pc_write=0, IFID_write=0. Next state is TRAP, and cnt is cleared (an in-flight CSR op is aborted).
  3. CSR_BUSY: CSR_stall=1, pc_write=0, IFID_write=0.
     - If mem=0: cnt decrements; at cnt==0 the next state is CSR_DONE.
     - If mem=1: cnt holds.
  4. mem=1 in IDLE or CSR_DONE: pc_write=0, IFID_write=0, no flush (freeze dominates flush). The state holds.
  5. branch_taken=1: IFID_flush=1, Control_flush=1, pc_write=1. flush_count increments. branch_taken overrides lu.
  6. lu=1: pc_write=0, IFID_write=0, Control_flush=1.
  7. IDLE with EXE_CSRSel=1: next state is CSR_BUSY with cnt=CSR_LAT-1; this cycle's outputs are from rules 4-6 or default.
     - Total CSR_stall-high cycles equal CSR_LAT, plus any mem-stall cycles.
  8. CSR_DONE with mem=0: default outputs, EXE_CSRSel is ignored (no re-trigger), next state is IDLE.
- stall_cycles increments on every non-reset cycle with pc_write=0.
- Both counters wrap modulo 2^CNT_W.
- CSR_LAT=1: CSR_BUSY lasts exactly one cycle.

Test Plan:
- Load-use: EXE_MemRead=1, EXE_write_addr=5, ID_rs2_addr=5, ID_use_rs2=1, both _f=0 → pc_write=0, IFID_write=0, Control_flush=1 for 1 cycle, stall_cycles=1. The same stimulus with addr 0 → no stall.
- FP distinction: EXE_dest_f=1, EXE_write_addr=0, ID_rs1_f=1, ID_rs1_addr=0 → stall. With ID_rs1_f=0 → no stall.
- CSR sequence: CSR_LAT=3, EXE_CSRSel held at 1 from cycle 0 → CSR_stall=1 in cycles 1-3, CSR_DONE in cycle 4 with CSR_stall=0, IDLE in cycle 5. dm_stall=1 in cycle 2 → CSR_stall is high in cycles 1-4.
- Trap mid-CSR: csr_trap pulse in the second CSR_BUSY cycle → next cycle CSR_reset=1, IFID_flush=1, CSR_stall=0, then IDLE.
- Simultaneous branch_taken=1 and lu=1 → IFID_flush=1, Control_flush=1, pc_write=1, flush_count +1. Adding im_stall=1 to the same cycle → no flush, pc_write=0, flush_count unchanged.
- Reset asserted during CSR_BUSY → next cycle is IDLE, counters 0, CSR_stall=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch handling, a CSR
// sequencing FSM with trap flush, and stall/flush performance counters.
module hazard_ctrl #(
    parameter int CSR_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_rs1_f,
    input  logic             ID_rs2_f,
    input  logic             EXE_MemRead,
    input  logic [4:0]       EXE_write_addr,
    input  logic             EXE_dest_f,
    input  logic             EXE_CSRSel,
    input  logic             branch_taken,
    input  logic             csr_trap,
    input  logic             im_stall,
    input  logic             dm_stall,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             Control_flush,
    output logic             CSR_stall,
    output logic             CSR_reset,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE,
        CSR_BUSY,
        CSR_DONE,
        TRAP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(CSR_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic mem;
    logic rs1_hit;
    logic rs2_hit;
    logic lu;
    logic flush_event;

    // Integer x0 is hardwired to zero and can never be a real producer; FP f0 can.
    always_comb begin
        mem     = im_stall | dm_stall;
        rs1_hit = ID_use_rs1 && (ID_rs1_addr == EXE_write_addr) &&
                  (ID_rs1_f == EXE_dest_f) && (EXE_dest_f || (EXE_write_addr != 5'd0));
        rs2_hit = ID_use_rs2 && (ID_rs2_addr == EXE_write_addr) &&
                  (ID_rs2_f == EXE_dest_f) && (EXE_dest_f || (EXE_write_addr != 5'd0));
        lu      = EXE_MemRead && (rs1_hit || rs2_hit);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b1;
        IFID_write    = 1'b1;
        IFID_flush    = 1'b0;
        Control_flush = 1'b0;
        CSR_stall     = 1'b0;
        CSR_reset     = 1'b0;
        flush_event   = 1'b0;

        if (reset) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            state_d    = IDLE;
            cnt_d      = 4'd0;
        end else if (state_q == TRAP) begin
            CSR_reset  = 1'b1;
            IFID_flush = 1'b1;
            IFID_write = 1'b0;
            state_d    = IDLE;
        end else if (csr_trap) begin
            // Abort whatever is in flight; the flush itself happens in TRAP.
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            state_d    = TRAP;
            cnt_d      = 4'd0;
        end else if (state_q == CSR_BUSY) begin
            CSR_stall  = 1'b1;
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            if (!mem) begin
                if (cnt_q == 4'd0) begin
                    state_d = CSR_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end else if (mem) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
        end else begin
            if (branch_taken) begin
                IFID_flush    = 1'b1;
                Control_flush = 1'b1;
                flush_event   = 1'b1;
            end else if (lu) begin
                pc_write      = 1'b0;
                IFID_write    = 1'b0;
                Control_flush = 1'b1;
            end
            // CSR_DONE never re-triggers, so a held EXE_CSRSel runs one op only.
            if (state_q == CSR_DONE) begin
                state_d = IDLE;
            end else if (EXE_CSRSel) begin
                state_d = CSR_BUSY;
                cnt_d   = CNT_INIT;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flush_event) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int CSR_LAT = 3;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_rs1_addr, ID_rs2_addr, EXE_write_addr;
    logic             ID_use_rs1, ID_use_rs2, ID_rs1_f, ID_rs2_f;
    logic             EXE_MemRead, EXE_dest_f, EXE_CSRSel;
    logic             branch_taken, csr_trap, im_stall, dm_stall;
    logic             pc_write, IFID_write, IFID_flush, Control_flush, CSR_stall, CSR_reset;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    // Model: remaining CSR stall cycles, a pending post-trap flush, and a
    // one-cycle "CSR just finished" guard against retriggering.
    int          m_busy_left;
    bit          m_trap_pending;
    bit          m_done_guard;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    hazard_ctrl #(.CSR_LAT(CSR_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_rs1_f(ID_rs1_f), .ID_rs2_f(ID_rs2_f),
        .EXE_MemRead(EXE_MemRead), .EXE_write_addr(EXE_write_addr),
        .EXE_dest_f(EXE_dest_f), .EXE_CSRSel(EXE_CSRSel),
        .branch_taken(branch_taken), .csr_trap(csr_trap),
        .im_stall(im_stall), .dm_stall(dm_stall),
        .pc_write(pc_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .Control_flush(Control_flush), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic rst, input logic mrd, input logic [4:0] wa, input logic df,
        input logic [4:0] r1, input logic f1, input logic u1,
        input logic [4:0] r2, input logic f2, input logic u2,
        input logic csr, input logic br, input logic trp, input logic ims, input logic dms);
        reset = rst; EXE_MemRead = mrd; EXE_write_addr = wa; EXE_dest_f = df;
        ID_rs1_addr = r1; ID_rs1_f = f1; ID_use_rs1 = u1;
        ID_rs2_addr = r2; ID_rs2_f = f2; ID_use_rs2 = u2;
        EXE_CSRSel = csr; branch_taken = br; csr_trap = trp;
        im_stall = ims; dm_stall = dms;
    endtask

    task automatic idleStimulus(input logic rst);
        applyStimulus(rst, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit srcMatches(input logic use_it, input logic [4:0] a, input logic f);
        if (!use_it || a != EXE_write_addr || f != EXE_dest_f) return 0;
        return !(a == 5'd0 && !f);
    endfunction

    // Evaluates one cycle: compare outputs against the model, then advance it.
    task automatic runCycle(input string tag);
        bit e_pc, e_ifw, e_iff, e_cf, e_cs, e_cr, mem, lu;
        #1;
        e_pc = 1; e_ifw = 1; e_iff = 0; e_cf = 0; e_cs = 0; e_cr = 0;
        mem = im_stall || dm_stall;
        lu  = EXE_MemRead && (srcMatches(ID_use_rs1, ID_rs1_addr, ID_rs1_f) ||
                              srcMatches(ID_use_rs2, ID_rs2_addr, ID_rs2_f));
        if (reset) begin
            e_pc = 0; e_ifw = 0;
        end else if (m_trap_pending) begin
            e_cr = 1; e_iff = 1; e_ifw = 0;
        end else if (csr_trap) begin
            e_pc = 0; e_ifw = 0;
        end else if (m_busy_left > 0) begin
            e_cs = 1; e_pc = 0; e_ifw = 0;
        end else if (mem) begin
            e_pc = 0; e_ifw = 0;
        end else if (branch_taken) begin
            e_iff = 1; e_cf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_cf = 1;
        end
        checkOutput({tag, ".pc_write"}, 32'(pc_write), 32'(e_pc));
        checkOutput({tag, ".IFID_write"}, 32'(IFID_write), 32'(e_ifw));
        checkOutput({tag, ".IFID_flush"}, 32'(IFID_flush), 32'(e_iff));
        checkOutput({tag, ".Control_flush"}, 32'(Control_flush), 32'(e_cf));
        checkOutput({tag, ".CSR_stall"}, 32'(CSR_stall), 32'(e_cs));
        checkOutput({tag, ".CSR_reset"}, 32'(CSR_reset), 32'(e_cr));
        checkOutput({tag, ".stall_cycles"}, stall_cycles, m_stalls);
        checkOutput({tag, ".flush_count"}, flush_count, m_flushes);

        if (reset) begin
            m_busy_left = 0; m_trap_pending = 0; m_done_guard = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (!e_pc) m_stalls = m_stalls + 1;
            if (m_trap_pending) begin
                m_trap_pending = 0; m_busy_left = 0; m_done_guard = 0;
            end else if (csr_trap) begin
                m_trap_pending = 1; m_busy_left = 0; m_done_guard = 0;
            end else if (m_busy_left > 0) begin
                if (!mem) begin
                    m_busy_left--;
                    if (m_busy_left == 0) m_done_guard = 1;
                end
            end else if (!mem) begin
                if (branch_taken) m_flushes = m_flushes + 1;
                if (m_done_guard) m_done_guard = 0;
                else if (EXE_CSRSel) m_busy_left = CSR_LAT;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] snap;
        m_busy_left = 0; m_trap_pending = 0; m_done_guard = 0;
        m_stalls = 0; m_flushes = 0;

        idleStimulus(1);
        @(negedge clk);
        runCycle("reset");
        idleStimulus(0);
        runCycle("idle");
        checkOutput("idle_pc_const", 32'(pc_write), 32'd1);

        // Load-use on rs2, then the same with x0 (no hazard).
        snap = m_stalls;
        applyStimulus(0, 1, 5'd5, 0, 5'd1, 0, 0, 5'd5, 0, 1, 0, 0, 0, 0, 0);
        runCycle("lu_rs2");
        idleStimulus(0);
        runCycle("lu_after");
        checkOutput("lu_stall_delta", stall_cycles - snap, 32'd1);
        applyStimulus(0, 1, 5'd0, 0, 5'd1, 0, 0, 5'd0, 0, 1, 0, 0, 0, 0, 0);
        runCycle("lu_x0");

        // FP f0 hazards; integer reader of register 0 does not match FP f0.
        applyStimulus(0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        runCycle("lu_f0");
        applyStimulus(0, 1, 5'd0, 1, 5'd0, 0, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        runCycle("lu_f0_int");

        // CSR op with EXE_CSRSel held: stall cycles 1..3, done in 4, idle in 5.
        for (int c = 0; c < 7; c++) begin
            applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0);
            runCycle($sformatf("csr_c%0d", c));
        end
        idleStimulus(0);
        runCycle("csr_gap");
        // Same with a data-memory stall in cycle 2.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, (c == 2));
            runCycle($sformatf("csrdm_c%0d", c));
        end
        idleStimulus(0);
        runCycle("csrdm_gap");

        // Trap pulse during the second CSR_BUSY cycle.
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0);
        runCycle("trap_c0");
        runCycle("trap_c1");
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0, 0);
        runCycle("trap_c2");
        idleStimulus(0);
        checkOutput("trap_flush_const", 32'(CSR_reset), 32'd1);
        runCycle("trap_c3");
        runCycle("trap_c4");

        // Branch beats load-use; memory freeze beats branch.
        snap = m_flushes;
        applyStimulus(0, 1, 5'd7, 0, 5'd7, 0, 1, 5'd0, 0, 0, 0, 1, 0, 0, 0);
        runCycle("br_lu");
        applyStimulus(0, 1, 5'd7, 0, 5'd7, 0, 1, 5'd0, 0, 0, 0, 1, 0, 1, 0);
        runCycle("br_lu_ims");
        idleStimulus(0);
        runCycle("br_after");
        checkOutput("br_flush_delta", flush_count - snap, 32'd1);

        // Reset while CSR_BUSY.
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 0);
        runCycle("rstb_c0");
        runCycle("rstb_c1");
        idleStimulus(1);
        runCycle("rstb_rst");
        idleStimulus(0);
        runCycle("rstb_after");
        checkOutput("rstb_stall_const", stall_cycles, 32'd0);

        // Random traffic; EXE_CSRSel never coincides with a memory stall.
        for (int i = 0; i < 600; i++) begin
            logic csr_r, mem_r;
            csr_r = ($urandom_range(0, 4) == 0);
            mem_r = !csr_r && ($urandom_range(0, 4) == 0);
            applyStimulus(($urandom_range(0, 59) == 0), $urandom_range(0, 1),
                          5'($urandom_range(0, 3)), $urandom_range(0, 1),
                          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                          csr_r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                          mem_r && $urandom_range(0, 1), mem_r && $urandom_range(0, 1));
            runCycle($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
